// File: rtl/sram_scan_pkg.sv
// -----------------------------------------------------------------------------
// sram_scan_pkg
// Shared types and constants for the serial-command SRAM test controller.
//   op_t       : frame opcode (NOP, WRITE, READ, WRITE-then-READ)
//   state_t    : controller FSM state, also exported on the debug port
//   MISR_POLY  : feedback taps for the optional read-signature register
//                (used only when SRAM_SCAN_CTRL_SIG_EN is defined)
//   frame_w()  : total width of the serial command/result frame
// -----------------------------------------------------------------------------
package sram_scan_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_WRRD = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        NEXT    = 3'd4,
        FIN     = 3'd5
    } state_t;

    // x^32 + x^22 + x^2 + x + 1; the low DATA_W bits are used as taps.
    localparam logic [63:0] MISR_POLY = 64'h0000_0000_8020_0003;

    // Frame layout, MSB to LSB: op[1:0], cnt, addr, wmask, data.
    function automatic int frame_w(input int cnt_w, input int addr_w,
                                   input int wmask_w, input int data_w);
        return 2 + cnt_w + addr_w + wmask_w + data_w;
    endfunction

endpackage

// File: rtl/sram_scan_frame.sv
// -----------------------------------------------------------------------------
// sram_scan_frame
// Serial frame register. Shifts right one bit per enabled cycle (new bit enters
// at the MSB, bit 0 is the serial output) and can overwrite its data field
// [DATA_W-1:0] in parallel with a captured word.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the frame)
//   shift_en   : shift one bit this cycle
//   serial_in  : bit entering at the MSB
//   load_en    : overwrite the data field with load_data (wins over shift)
//   load_data  : word to load into [DATA_W-1:0]
//   frame      : full frame contents
// -----------------------------------------------------------------------------
module sram_scan_frame #(
    parameter int FRAME_W = 54,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               serial_in,
    input  logic               load_en,
    input  logic [DATA_W-1:0]  load_data,
    output logic [FRAME_W-1:0] frame
);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
        end else if (load_en) begin
            frame[DATA_W-1:0] <= load_data;
        end else if (shift_en) begin
            frame <= {serial_in, frame[FRAME_W-1:1]};
        end
    end

endmodule

// File: rtl/sram_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sram_scan_ctrl
// Serial-command SRAM test controller. A frame shifted in on scan_in holds
// {op, cnt, addr, wmask, data}. On start the controller runs cnt+1 accesses
// with address auto-increment against one OpenRAM macro, captures read data
// into the frame data field, and the result is shifted back out on scan_out.
//
// Optional build macro: SRAM_SCAN_CTRL_SIG_EN -- when defined, read words are
// folded into a DATA_W-bit MISR (cleared at start) and the MISR value replaces
// the frame data field when the burst finishes.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   scan_en/scan_in : shift the frame one bit per cycle (IDLE only)
//   scan_out        : frame bit 0
//   start           : execute request, sampled in IDLE
//   busy, done      : burst in progress / one-cycle completion pulse
//   sram_*          : registered macro controls, sram_dout is macro read data
//   sram_spare_wen  : spare-column write enable (top mask bit of a write)
//   fsm_state       : current FSM state (state_t encoding) for observation
//
// Handshake: start is accepted on a clock edge where the FSM is IDLE, start=1
// and scan_en=0; busy is high from the next cycle until the burst's last
// access is retired, then done pulses high for exactly one cycle (busy low)
// and the FSM is back in IDLE the cycle after. A NOP frame produces the done
// pulse directly with no busy cycles. start and scan_en are ignored outside
// IDLE.
// -----------------------------------------------------------------------------
module sram_scan_ctrl
    import sram_scan_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int WMASK_W  = 4,   // DATA_W must be a multiple of WMASK_W
    parameter int CNT_W    = 8,
    parameter int READ_LAT = 1    // 1..4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_en,
    input  logic               scan_in,
    output logic               scan_out,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               sram_csb,
    output logic               sram_web,
    output logic [WMASK_W-1:0] sram_wmask,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [DATA_W-1:0]  sram_din,
    output logic               sram_spare_wen,
    input  logic [DATA_W-1:0]  sram_dout,
    output logic [2:0]         fsm_state
);

    localparam int FRAME_W  = frame_w(CNT_W, ADDR_W, WMASK_W, DATA_W);
    localparam int WMASK_LO = DATA_W;
    localparam int ADDR_LO  = WMASK_LO + WMASK_W;
    localparam int CNT_LO   = ADDR_LO + ADDR_W;
    localparam int OP_LO    = CNT_LO + CNT_W;
    // WAIT lasts READ_LAT-1 cycles: load the counter with READ_LAT-2 and leave
    // when it reaches zero. READ_LAT=1 skips WAIT entirely.
    localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    state_t               state, state_nx;
    op_t                  op_r, op_nx;
    logic [CNT_W-1:0]     cnt_r, cnt_nx;
    logic [ADDR_W-1:0]    addr_r, addr_nx;
    logic [WMASK_W-1:0]   wmask_r, wmask_nx;
    logic [DATA_W-1:0]    data_r, data_nx;
    logic                 phase_r, phase_nx;  // 1 = current access is a read
    logic [1:0]           wait_cnt, wait_nx;

    logic [FRAME_W-1:0]   frame;
    logic                 shift_en;
    logic                 cap_en;
    logic                 load_en;
    logic [DATA_W-1:0]    load_data;
    op_t                  f_op;

    assign f_op = op_t'(frame[OP_LO +: 2]);

    // ---------------------------------------------------------------- FSM ---
    always_comb begin
        state_nx = state;
        op_nx    = op_r;
        cnt_nx   = cnt_r;
        addr_nx  = addr_r;
        wmask_nx = wmask_r;
        data_nx  = data_r;
        phase_nx = phase_r;
        wait_nx  = wait_cnt;
        case (state)
            IDLE: begin
                if (start && !scan_en) begin
                    // Fields are frozen here; later shifts or captures into
                    // the frame do not affect the running burst.
                    op_nx    = f_op;
                    cnt_nx   = frame[CNT_LO +: CNT_W];
                    addr_nx  = frame[ADDR_LO +: ADDR_W];
                    wmask_nx = frame[WMASK_LO +: WMASK_W];
                    data_nx  = frame[DATA_W-1:0];
                    phase_nx = (f_op == OP_RD);
                    state_nx = (f_op == OP_NOP) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (phase_r) begin
                    wait_nx  = WAIT_INIT;
                    state_nx = (READ_LAT == 1) ? CAPTURE : WAIT;
                end else begin
                    state_nx = NEXT;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) state_nx = CAPTURE;
                else                  wait_nx  = wait_cnt - 2'd1;
            end
            CAPTURE: state_nx = NEXT;
            NEXT: begin
                if (op_r == OP_WRRD && !phase_r) begin
                    // Same address: follow the write with its read.
                    phase_nx = 1'b1;
                    state_nx = ISSUE;
                end else if (cnt_r == '0) begin
                    state_nx = FIN;
                end else begin
                    cnt_nx   = cnt_r - CNT_W'(1);
                    addr_nx  = addr_r + ADDR_W'(1);
                    phase_nx = (op_r == OP_RD);
                    state_nx = ISSUE;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Macro controls are registered from the next-state decode so that they
    // change exactly on entry to / exit from ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_r       <= OP_NOP;
            cnt_r      <= '0;
            addr_r     <= '0;
            wmask_r    <= '0;
            data_r     <= '0;
            phase_r    <= 1'b0;
            wait_cnt   <= 2'd0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
        end else begin
            state    <= state_nx;
            op_r     <= op_nx;
            cnt_r    <= cnt_nx;
            addr_r   <= addr_nx;
            wmask_r  <= wmask_nx;
            data_r   <= data_nx;
            phase_r  <= phase_nx;
            wait_cnt <= wait_nx;
            sram_csb <= (state_nx != ISSUE);
            sram_web <= !((state_nx == ISSUE) && !phase_nx);
            if (state_nx == ISSUE) begin
                sram_wmask <= wmask_nx;
                sram_addr  <= addr_nx;
                sram_din   <= data_nx;
            end
        end
    end

    assign busy           = (state == ISSUE) || (state == WAIT) ||
                            (state == CAPTURE) || (state == NEXT);
    assign done           = (state == FIN);
    assign fsm_state      = state;
    assign sram_spare_wen = !sram_csb && !sram_web && sram_wmask[WMASK_W-1];

    // ------------------------------------------------------- frame / MISR ---
    assign shift_en = scan_en && (state == IDLE);
    assign cap_en   = (state == CAPTURE);

`ifdef SRAM_SCAN_CTRL_SIG_EN
    localparam logic [DATA_W-1:0] POLY = MISR_POLY[DATA_W-1:0];
    logic [DATA_W-1:0] misr;
    logic              misr_fb;
    logic              misr_clr;

    assign misr_fb  = ^(misr & POLY);
    assign misr_clr = (state == IDLE) && start && !scan_en;

    always_ff @(posedge clk) begin
        if (rst || misr_clr) begin
            misr <= '0;
        end else if (cap_en) begin
            misr <= {misr[DATA_W-2:0], misr_fb} ^ sram_dout;
        end
    end

    assign load_en   = (state == FIN);
    assign load_data = misr;
`else
    assign load_en   = cap_en;
    assign load_data = sram_dout;
`endif

    sram_scan_frame #(
        .FRAME_W (FRAME_W),
        .DATA_W  (DATA_W)
    ) u_frame (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .serial_in (scan_in),
        .load_en   (load_en),
        .load_data (load_data),
        .frame     (frame)
    );

    assign scan_out = frame[0];

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_scan_ctrl
// Bench for sram_scan_ctrl (default build, READ_LAT=2) with a behavioural
// SRAM macro model. Directed frames come from a vector table; random frames
// are checked against a reference model that derives the access list, cycle
// count and returned word from the opcode rules.
// -----------------------------------------------------------------------------
module tb_sram_scan_ctrl;
    import sram_scan_pkg::*;

    localparam int RL      = 2;
    localparam int FRAME_W = 54;
    localparam int ACC_W   = 46;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic        scan_in;
    logic        scan_out;
    logic        start;
    logic        busy;
    logic        done;
    logic        sram_csb;
    logic        sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic        sram_spare_wen;
    logic [31:0] sram_dout;
    logic [2:0]  fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ACC_W-1:0] exp_q[$];
    logic [31:0]      ref_mem [256];

    sram_scan_ctrl #(
        .ADDR_W(8), .DATA_W(32), .WMASK_W(4), .CNT_W(8), .READ_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out), .start(start), .busy(busy), .done(done),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_spare_wen(sram_spare_wen), .sram_dout(sram_dout),
        .fsm_state(fsm_state)
    );

    // ---------------------------------------------------- clock / reset ---
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // --------------------------------------------------- SRAM macro model ---
    logic        mem_init;
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [RL];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            for (int k = 0; k < RL; k++) rd_pipe[k] <= 32'h0;
        end else begin
            if (!sram_csb) begin
                if (!sram_web) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end else begin
                    rd_pipe[0] <= mem[sram_addr];
                end
            end
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign sram_dout = rd_pipe[RL-1];

    // ------------------------------------------------------- scoreboard ---
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] acc_enc(input logic we, input logic spare,
                                                 input logic [7:0] a, input logic [3:0] m,
                                                 input logic [31:0] d);
        if (we) return {1'b1, spare, a, m, d};
        return {1'b0, spare, a, 4'h0, 32'h0};
    endfunction

    // ---------------------------------------------------------- drivers ---
    task automatic shift_in(input logic [FRAME_W-1:0] f);
        for (int i = 0; i < FRAME_W; i++) begin
            @(negedge clk);
            scan_en = 1'b1;
            scan_in = f[i];
        end
        @(negedge clk);
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic shift_out(output logic [FRAME_W-1:0] f);
        for (int i = 0; i < FRAME_W; i++) begin
            @(negedge clk);
            f[i]    = scan_out;
            scan_en = 1'b1;
            scan_in = 1'b0;
        end
        @(negedge clk);
        scan_en = 1'b0;
    endtask

    // Reference model + execution of one frame. Expected accesses, cycle count
    // and returned word are computed from the opcode rules before the run.
    task automatic run_frame(input logic [1:0] op, input logic [7:0] cnt,
                             input logic [7:0] addr, input logic [3:0] wm,
                             input logic [31:0] data, input bit jitter,
                             output int busy_n, output logic [31:0] word);
        logic [31:0]        w;
        logic [31:0]        last;
        logic [7:0]         a;
        int                 cyc;
        int                 done_at;
        bit                 done_seen;
        logic [FRAME_W-1:0] f_out;
        bit                 has_wr;
        bit                 has_rd;

        has_wr = (op == 2'b01) || (op == 2'b11);
        has_rd = (op == 2'b10) || (op == 2'b11);
        cyc    = 0;
        last   = data;
        exp_q.delete();
        if (op != 2'b00) begin
            for (int k = 0; k <= int'(cnt); k++) begin
                a = 8'((int'(addr) + k) % 256);
                if (has_wr) begin
                    w = ref_mem[a];
                    for (int b = 0; b < 4; b++)
                        if (wm[b]) w[8*b +: 8] = data[8*b +: 8];
                    ref_mem[a] = w;
                    exp_q.push_back(acc_enc(1'b1, wm[3], a, wm, data));
                    cyc += 2;
                end
                if (has_rd) begin
                    exp_q.push_back(acc_enc(1'b0, 1'b0, a, 4'h0, 32'h0));
                    last = ref_mem[a];
                    cyc += 2 + RL;
                end
            end
        end

        shift_in({op, cnt, addr, wm, data});
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        busy_n    = 0;
        done_at   = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 500 && !done_seen; c++) begin
            if (!sram_csb) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL access: unexpected csb pulse at addr %h, none expected", sram_addr);
                end else begin
                    check("access", acc_enc(!sram_web, sram_spare_wen, sram_addr, sram_wmask, sram_din),
                          exp_q.pop_front());
                end
            end
            if (busy) busy_n++;
            if (done) begin
                done_seen = 1'b1;
                done_at   = c + 1;
                scan_en   = 1'b0;
                scan_in   = 1'b0;
                start     = 1'b0;
            end else begin
                if (jitter) begin
                    scan_en = 1'($urandom_range(0, 1));
                    scan_in = 1'($urandom_range(0, 1));
                    start   = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
        end
        check("done_seen", done_seen, 1);
        check("busy_cycles", busy_n, cyc);
        check("done_cycle", done_at, cyc + 1);
        check("missing_access", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("done_width", done, 0);
        check("idle_after", fsm_state, IDLE);
        shift_out(f_out);
        check("frame_out", f_out, {op, cnt, addr, wm, last});
        word = f_out[31:0];
    endtask

    // ------------------------------------------------------ vector table ---
    typedef struct {
        logic [1:0]  op;
        logic [7:0]  cnt;
        logic [7:0]  addr;
        logic [3:0]  wm;
        logic [31:0] data;
        int          exp_busy;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          busy_n;
        int          csb_n;
        int          busy_seen;
        bit          found;
        logic [31:0] word;
        logic [FRAME_W-1:0] f_out;

        vecs[0] = '{2'b01, 8'd0, 8'h10, 4'hF, 32'hDEADBEEF, 2,  32'hDEADBEEF};
        vecs[1] = '{2'b10, 8'd0, 8'h10, 4'hF, 32'h00000000, 4,  32'hDEADBEEF};
        vecs[2] = '{2'b01, 8'd3, 8'hFE, 4'hF, 32'hA5A5A5A5, 8,  32'hA5A5A5A5};
        vecs[3] = '{2'b01, 8'd0, 8'h40, 4'hF, 32'hFFFFFFFF, 2,  32'hFFFFFFFF};
        vecs[4] = '{2'b11, 8'd0, 8'h40, 4'h1, 32'h12345678, 6,  32'hFFFFFF78};
        vecs[5] = '{2'b00, 8'd0, 8'h33, 4'hF, 32'h0BADF00D, 0,  32'h0BADF00D};
        vecs[6] = '{2'b10, 8'd1, 8'hFF, 4'h0, 32'h00000000, 8,  32'hA5A5A5A5};
        vecs[7] = '{2'b11, 8'd1, 8'hFF, 4'hC, 32'h11223344, 12, 32'h1122A5A5};

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        rst      = 1'b1;
        mem_init = 1'b1;
        scan_en  = 1'b0;
        scan_in  = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_csb", sram_csb, 1);
        check("rst_web", sram_web, 1);
        check("rst_wmask", sram_wmask, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_din", sram_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_scan_out", scan_out, 0);
        check("rst_state", fsm_state, IDLE);
        rst      = 1'b0;
        mem_init = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].op, vecs[i].cnt, vecs[i].addr, vecs[i].wm, vecs[i].data,
                      1'b0, busy_n, word);
            check("tbl_busy", busy_n, vecs[i].exp_busy);
            check("tbl_word", word, vecs[i].exp_word);
        end

        // start together with scan_en in IDLE must not launch an access
        shift_in({2'b01, 8'd0, 8'h20, 4'hF, 32'h55555555});
        scan_en = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        scan_en   = 1'b0;
        start     = 1'b0;
        csb_n     = 0;
        busy_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (!sram_csb) csb_n++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        check("guard_csb", csb_n, 0);
        check("guard_busy", busy_seen, 0);
        check("guard_state", fsm_state, IDLE);

        // scan_en / start / scan_in toggling while busy: frame must be intact
        run_frame(2'b10, 8'd3, 8'h3E, 4'h0, 32'h0, 1'b1, busy_n, word);
        run_frame(2'b11, 8'd2, 8'hFE, 4'h6, 32'hCAFE1234, 1'b1, busy_n, word);

        // Reset during WAIT of a read
        shift_in({2'b10, 8'd0, 8'h10, 4'hF, 32'h0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (fsm_state == WAIT) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_rst_reach_wait", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_csb", sram_csb, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_state", fsm_state, IDLE);
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_start_done", done, 1);
        check("post_rst_csb", sram_csb, 1);
        @(negedge clk);
        check("post_rst_done_low", done, 0);
        shift_out(f_out);
        check("mid_rst_frame_clear", f_out, 0);

        // Randomized frames against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            ra = ($urandom_range(0, 2) == 0) ? 8'(8'hFC + $urandom_range(0, 3))
                                             : 8'($urandom_range(0, 255));
            run_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)), ra,
                      4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
                      busy_n, word);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_scan_ctrl.md
Name: sram_scan_ctrl

Overview:
- Single-clock, serial-command SRAM test controller.
- Successor to the two-phase scan chain plus SRAM test top.
- A frame shifted in over one pin carries the opcode, repeat count, start address, write mask and data. On `start`, the block runs a burst of SRAM accesses with address auto-increment, captures read data, and shifts the result back out.
- Sits between the chip pins and one OpenRAM macro clocked by `clk`.

Parameters:
- ADDR_W, 8, SRAM address width.
- DATA_W, 32, SRAM data width.
- WMASK_W, 4, write-mask width. DATA_W must be divisible by WMASK_W.
- CNT_W, 8, repeat-count field width. A burst length of N+1 is encoded as N.
- READ_LAT, 1, cycles from the clock edge that samples csb low to valid dout. Legal range is 1..4.

Ports:
- clk, input, 1, single clock. SRAM and controller both run on it.
- rst, input, 1, synchronous, active-high reset.
- scan_en, input, 1, shift enable. While high, the frame register shifts one bit per cycle.
- scan_in, input, 1, serial input. Enters the frame MSB.
- scan_out, output, 1, serial output. Equals frame register bit 0.
- start, input, 1, execute request. Sampled in IDLE only.
- busy, output, 1, high while a burst is executing.
- done, output, 1, one-cycle pulse when a burst completes.
- sram_csb, output, 1, chip select, active-low. Registered output.
- sram_web, output, 1, write enable, active-low. Registered output.
- sram_wmask, output, WMASK_W, byte write mask. Registered output.
- sram_addr, output, ADDR_W, address. Registered output.
- sram_din, output, DATA_W, write data. Registered output.
- sram_spare_wen, output, 1, spare-column write enable. Equals sram_wmask[WMASK_W-1] AND write.
- sram_dout, input, DATA_W, read data from the macro.

Behaviour:
- Frame layout, FRAME_W = 2+CNT_W+ADDR_W+WMASK_W+DATA_W bits, listed MSB to LSB: op[1:0], cnt, addr, wmask, data. Data sits at [DATA_W-1:0].
- Opcodes:
  - 00: NOP.
  - 01: WRITE.
  - 10: READ.
  - 11: WRITE-then-READ per address. Each address gets a write access, then a read access.
- Shifting: when scan_en=1 and the FSM is in IDLE, frame <= {scan_in, frame[FRAME_W-1:1]}. Otherwise the frame holds.
- Reset values: frame=0, state=IDLE, busy=0, done=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, NEXT, FIN.
- IDLE:
  - start=1 with scan_en=0 latches the frame fields into working registers, sets busy, and moves to ISSUE.
  - start with scan_en=1 in the same cycle: start is ignored.
  - op=00: go directly to FIN.
- ISSUE: drive csb=0 for exactly one cycle, with web, wmask, addr and din set for the current access.
  - Write access: go to NEXT.
  - Read access: go to WAIT.
- WAIT: count READ_LAT-1 cycles, then go to CAPTURE.
  - Capture timing: the dout sample lands READ_LAT edges after the edge that sampled csb=0.
- CAPTURE: frame[DATA_W-1:0] <= sram_dout, then go to NEXT.
- NEXT:
  - If remaining count is 0, go to FIN.
  - Otherwise decrement the count, increment addr modulo 2^ADDR_W (0xFF wraps to 0x00), and go to ISSUE.
  - For op 11, the write and read of the same address both complete before the address increments.
- FIN: done=1 for one cycle, busy=0, then go to IDLE.
- Pins that are ignored:
  - scan_en and start while busy.
  - din/wmask changes are frozen from the start cycle onward.
- Outside ISSUE, csb=1 and web=1.
- Reset mid-burst: at the next edge, csb=1 and state=IDLE. No done pulse, and the frame is cleared.
- Per-access throughput:
  - Write: 2 cycles.
  - Read: 2+READ_LAT cycles.

Optional Feature:
- Macro: SRAM_SCAN_CTRL_SIG_EN.
- Defined:
  - A DATA_W-bit MISR (polynomial given as a package constant) is cleared at start.
  - In CAPTURE the MISR folds in sram_dout: misr <= {misr[DATA_W-2:0], fb} ^ sram_dout.
  - In FIN, frame data is loaded with the MISR value instead of the last word.
- Undefined: no MISR is built, and frame data holds the last read word.

Decomposition:
- Package sram_scan_pkg holds:
  - the opcode enum (OP_NOP, OP_WR, OP_RD, OP_WRRD);
  - the FSM state typedef;
  - the MISR polynomial constant;
  - the FRAME_W function.
- One sub-module, sram_scan_frame: the FRAME_W shift/capture register with a parallel-load port.

Test Plan:
- Write, shift-out check: shift frame op=01, cnt=0, addr=0x10, wmask=0xF, data=0xDEADBEEF, then start. Required response:
  - exactly one csb=0 cycle with web=0, addr=0x10, din=0xDEADBEEF;
  - done one cycle later;
  - busy high for 2 cycles.
- Read with READ_LAT=2: op=10, cnt=0, addr=0x10 after the write above. Required response:
  - capture 2 edges after csb low;
  - shift out 32 bits, LSB first, equal to 0xDEADBEEF.
- Burst wrap: op=01, cnt=3, addr=0xFE. Required response:
  - writes at 0xFE, 0xFF, 0x00, 0x01;
  - 4 csb pulses;
  - done after 8 cycles.
- Op 11 with wmask=0x1, data=0x12345678 over a location holding 0xFFFFFFFF. Required response: readback 0xFFFFFF78, and sram_spare_wen=0.
- Reset mid-burst: assert rst during the WAIT of op 10. Required response:
  - next cycle csb=1, busy=0, frame=0;
  - no done pulse;
  - start honoured on the first cycle after rst deasserts.
- Guards: pulse start together with scan_en in IDLE -> no access. Toggle scan_en while busy -> frame unchanged.
